load_store_unit: RTL and testbench

- Initiator side of the data-memory port: accepts one load or store request at a time from the multi-cycle core's execute stage.
- Legality-checks each request against the memory map, drives the byte-addressable 256-byte memory's port (wr_en, address, in_val, mem_size, mem_sz_ex_sel), and captures read data.
- Returns a single response to the core through a valid/ready handshake.
- Memory map: 0-63 instruction (read-only), 64-127 data, 128-255 memory-mapped I/O.

---
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
// Accepts one load/store at a time, rejects illegal accesses against the
// memory map (0..IMEM_TOP-1 read-only instruction space, MMIO from
// MMIO_BASE up to MEM_BYTES-1), drives the memory port, and returns one
// response per request over a valid/ready handshake.
module load_store_unit #(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_BYTES = 256,
  parameter int IMEM_TOP  = 64,
  parameter int MMIO_BASE = 128,
  parameter int READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // request channel from the execute stage
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  // response channel back to the core
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic                 resp_fault,
  output logic                 resp_mmio,
  // memory port
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_in_val,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex_sel,
  input  logic [BUS_WIDTH-1:0] mem_out_val
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // Map boundaries sized to the compare operands so no implicit widening occurs.
  localparam logic [BUS_WIDTH:0]   MEM_END = (BUS_WIDTH + 1)'(MEM_BYTES);
  localparam logic [BUS_WIDTH-1:0] IMEM_A  = BUS_WIDTH'(IMEM_TOP);
  localparam logic [BUS_WIDTH-1:0] MMIO_A  = BUS_WIDTH'(MMIO_BASE);

  localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] lat_cnt;
  logic             op_store;
  logic             req_fire;
  logic             req_fault;
  logic             misaligned;
  logic [2:0]       req_bytes;
  logic [BUS_WIDTH:0] req_end;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign req_fire   = req_valid && req_ready;

  // Byte count of the requested access; an illegal size is rejected separately.
  always_comb begin
    // NOTE: default assigned before the case so every path drives req_bytes and no latch is inferred.
    req_bytes = 3'd1;
    case (req_size)
      SZ_HALF: req_bytes = 3'd2;
      SZ_WORD: req_bytes = 3'd4;
      default: req_bytes = 3'd1;
    endcase
  end

  // One extra bit on the end address so addresses near 2^BUS_WIDTH cannot wrap past the bound.
  assign req_end    = {1'b0, req_addr} + (BUS_WIDTH + 1)'(req_bytes);
  assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_fault  = (req_size == SZ_ILLEGAL) || misaligned ||
                      (req_end > MEM_END) || (req_store && (req_addr < IMEM_A));

  // Request FSM plus registered memory-port and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register sees pre-edge values of the others.
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      op_store      <= 1'b0;
      resp_data     <= '0;
      resp_fault    <= 1'b0;
      resp_mmio     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_address   <= '0;
      mem_in_val    <= '0;
      mem_size      <= SZ_BYTE;
      mem_sz_ex_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            op_store  <= req_store;
            resp_data <= '0;
            if (req_fault) begin
              // Rejected: the memory port is left untouched.
              state      <= RESP;
              resp_fault <= 1'b1;
              resp_mmio  <= 1'b0;
            end else begin
              state         <= ISSUE;
              resp_fault    <= 1'b0;
              resp_mmio     <= (req_addr >= MMIO_A);
              mem_address   <= req_addr;
              mem_size      <= req_size;
              mem_sz_ex_sel <= req_unsigned;
              mem_wr_en     <= req_store;
              lat_cnt       <= LAT_INIT;
              if (req_store) begin
                mem_in_val <= req_wdata;
              end
            end
          end
        end
        ISSUE: begin
          if (op_store) begin
            // The write strobe was raised on entry; drop it after its single cycle.
            mem_wr_en <= 1'b0;
            state     <= RESP;
          end else if (lat_cnt == '0) begin
            resp_data <= mem_out_val;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit.
// Two instances (READ_LAT=1 and READ_LAT=2) share one byte memory; only the
// selected one receives req_valid. Expectations come from a shadow byte
// array and the memory-map rules evaluated with plain integer arithmetic.
module tb_load_store_unit;

  localparam int MEM_BYTES = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid, req_store, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready_w[2], resp_valid_w[2], resp_fault_w[2], resp_mmio_w[2];
  logic        mem_wr_en_w[2], mem_sz_ex_sel_w[2];
  logic [31:0] resp_data_w[2], mem_address_w[2], mem_in_val_w[2], mem_out_val_w[2];
  logic [1:0]  mem_size_w[2];

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(req_ready_w[0]), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready), .resp_data(resp_data_w[0]),
    .resp_fault(resp_fault_w[0]), .resp_mmio(resp_mmio_w[0]),
    .mem_wr_en(mem_wr_en_w[0]), .mem_address(mem_address_w[0]), .mem_in_val(mem_in_val_w[0]),
    .mem_size(mem_size_w[0]), .mem_sz_ex_sel(mem_sz_ex_sel_w[0]), .mem_out_val(mem_out_val_w[0])
  );

  load_store_unit #(.READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(req_ready_w[1]), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready), .resp_data(resp_data_w[1]),
    .resp_fault(resp_fault_w[1]), .resp_mmio(resp_mmio_w[1]),
    .mem_wr_en(mem_wr_en_w[1]), .mem_address(mem_address_w[1]), .mem_in_val(mem_in_val_w[1]),
    .mem_size(mem_size_w[1]), .mem_sz_ex_sel(mem_sz_ex_sel_w[1]), .mem_out_val(mem_out_val_w[1])
  );

  // Views of the instance currently under test.
  logic        req_ready_s, resp_valid_s, resp_fault_s, resp_mmio_s, mem_wr_en_s, mem_sz_ex_sel_s;
  logic [31:0] resp_data_s, mem_address_s, mem_in_val_s;
  logic [1:0]  mem_size_s;
  assign req_ready_s     = req_ready_w[sel];
  assign resp_valid_s    = resp_valid_w[sel];
  assign resp_fault_s    = resp_fault_w[sel];
  assign resp_mmio_s     = resp_mmio_w[sel];
  assign mem_wr_en_s     = mem_wr_en_w[sel];
  assign mem_sz_ex_sel_s = mem_sz_ex_sel_w[sel];
  assign resp_data_s     = resp_data_w[sel];
  assign mem_address_s   = mem_address_w[sel];
  assign mem_in_val_s    = mem_in_val_w[sel];
  assign mem_size_s      = mem_size_w[sel];

  // Memory environment: little-endian bytes, extension done by the memory.
  function automatic logic [31:0] env_read(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [7:0] i0, i1, i2, i3;
    i0 = a[7:0];
    i1 = i0 + 8'd1;
    i2 = i0 + 8'd2;
    i3 = i0 + 8'd3;
    case (sz)
      2'b00:   env_read = uns ? {24'd0, mem[i0]} : {{24{mem[i0][7]}}, mem[i0]};
      2'b01:   env_read = uns ? {16'd0, mem[i1], mem[i0]} : {{16{mem[i1][7]}}, mem[i1], mem[i0]};
      default: env_read = {mem[i3], mem[i2], mem[i1], mem[i0]};
    endcase
  endfunction

  always_comb begin
    mem_out_val_w[0] = env_read(mem_address_w[0], mem_size_w[0], mem_sz_ex_sel_w[0]);
    mem_out_val_w[1] = env_read(mem_address_w[1], mem_size_w[1], mem_sz_ex_sel_w[1]);
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_wr_en_w[i]) begin
          mem[mem_address_w[i][7:0]] <= mem_in_val_w[i][7:0];
          if (mem_size_w[i] != 2'b00) mem[mem_address_w[i][7:0] + 8'd1] <= mem_in_val_w[i][15:8];
          if (mem_size_w[i] == 2'b10) begin
            mem[mem_address_w[i][7:0] + 8'd2] <= mem_in_val_w[i][23:16];
            mem[mem_address_w[i][7:0] + 8'd3] <= mem_in_val_w[i][31:24];
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit ref_fault(input bit store, input logic [31:0] a, input logic [1:0] sz);
    longint addr;
    longint nb;
    addr = longint'({32'd0, a});
    if (sz == 2'b11) return 1'b1;
    nb = longint'(1) << sz;
    if (addr % nb != 0) return 1'b1;
    if (addr + nb > MEM_BYTES) return 1'b1;
    if (store && addr < 64) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input int addr, input int nb, input bit uns);
    longint v;
    v = 0;
    for (int k = 0; k < nb; k++) v += longint'(ref_mem[addr + k]) << (8 * k);
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input int addr, input int nb, input logic [31:0] wdata);
    for (int k = 0; k < nb; k++) ref_mem[addr + k] = 8'(wdata >> (8 * k));
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", req_ready_s, 1);
    check("rst_resp_valid", resp_valid_s, 0);
    check("rst_resp_data", resp_data_s, 0);
    check("rst_resp_fault", resp_fault_s, 0);
    check("rst_resp_mmio", resp_mmio_s, 0);
    check("rst_wr_en", mem_wr_en_s, 0);
    check("rst_address", mem_address_s, 0);
    check("rst_in_val", mem_in_val_s, 0);
    check("rst_size", mem_size_s, 0);
    check("rst_ex_sel", mem_sz_ex_sel_s, 0);
  endtask

  // One complete transaction: accept, wait for response, optional stall, handshake.
  task automatic txn(input bit s, input bit store, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input bit uns, input int stall);
    bit          f;
    int          lat, cyc, wr_cnt, nb;
    logic [31:0] exp_data;
    sel = s;
    f   = ref_fault(store, addr, size);
    nb  = 1 << size;
    lat = f ? 1 : (store ? 2 : 1 + (s ? 2 : 1));
    exp_data = (f || store) ? 32'd0 : ref_load(int'(addr), nb, uns);
    check("idle_req_ready", req_ready_s, 1);
    req_valid = 1'b1; req_store = store; req_addr = addr; req_wdata = wdata;
    req_size = size;  req_unsigned = uns;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    wr_cnt = 0;
    if (!f) begin
      check("issue_addr", mem_address_s, addr);
      check("issue_size", mem_size_s, size);
      check("issue_ex_sel", mem_sz_ex_sel_s, uns);
      if (store) check("issue_in_val", mem_in_val_s, wdata);
    end
    while (!resp_valid_s && cyc < 20) begin
      if (mem_wr_en_s) wr_cnt++;
      check("busy_req_ready", req_ready_s, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("resp_fault", resp_fault_s, f);
    check("resp_data", resp_data_s, exp_data);
    if (!f) check("resp_mmio", resp_mmio_s, addr >= 128);
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'b1; req_store = 1'b1; req_addr = 32'd80; req_size = 2'b00;
      @(posedge clk); #1;
      if (mem_wr_en_s) wr_cnt++;
      check("stall_valid", resp_valid_s, 1);
      check("stall_data", resp_data_s, exp_data);
      check("stall_req_ready", req_ready_s, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (mem_wr_en_s) wr_cnt++;
    check("resp_done", resp_valid_s, 0);
    check("wr_pulses", wr_cnt, (store && !f) ? 1 : 0);
    if (store && !f) ref_store(int'(addr), nb, wdata);
  endtask

  // Reset asserted while an access sits in ISSUE.
  task automatic reset_mid(input bit s, input bit store, input logic [31:0] addr);
    sel = s;
    check("idle_req_ready", req_ready_s, 1);
    req_valid = 1'b1; req_store = store; req_addr = addr; req_wdata = 32'hA5A5_5A5A;
    req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_in_issue", req_ready_s, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("post_rst_wr_en", mem_wr_en_s, 0);
      check("post_rst_valid", resp_valid_s, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_store = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 1'b0;
    for (int k = 0; k < MEM_BYTES; k++) begin
      mem[k]     = 8'($urandom);
      ref_mem[k] = mem[k];
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sel = 1'b0; check_reset_state();
    sel = 1'b1; check_reset_state();

    // Directed cases.
    txn(0, 0, 32'd0,   32'd0,         2'b10, 0, 0);
    txn(0, 1, 32'd65,  32'h0000_FFFF, 2'b00, 0, 0);
    txn(0, 1, 32'd4,   32'h0000_FFFF, 2'b10, 0, 0);
    txn(0, 0, 32'd4,   32'd0,         2'b10, 0, 0);
    txn(0, 1, 32'd128, 32'h0000_00C3, 2'b00, 0, 0);
    txn(0, 0, 32'd3,   32'd0,         2'b01, 0, 0);
    txn(0, 0, 32'd254, 32'd0,         2'b10, 0, 0);
    txn(0, 0, 32'd252, 32'd0,         2'b10, 0, 0);
    txn(0, 0, 32'd65,  32'd0,         2'b00, 0, 5);
    txn(1, 0, 32'd66,  32'd0,         2'b01, 1, 5);
    txn(1, 0, 32'd64,  32'd0,         2'b11, 0, 0);
    txn(1, 1, 32'hFFFF_FFFC, 32'd1,   2'b10, 0, 0);

    // Reset in the middle of a store (both latencies) and of a READ_LAT=2 load.
    reset_mid(0, 1, 32'd72);
    reset_mid(1, 1, 32'd76);
    reset_mid(1, 0, 32'd80);
    txn(0, 0, 32'd72, 32'd0, 2'b10, 0, 0);
    txn(1, 0, 32'd76, 32'd0, 2'b10, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      a  = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, 259)) : 32'($urandom);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 32'($urandom),
          sz, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
